// File: rtl/add_accum_stage.sv
// add_accum_stage: accumulates a stream of wide-add sums into a framed
// total, holding each result until downstream accepts it.
module add_accum_stage #(
    parameter int IN_W  = 47,
    parameter int ACC_W = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             ovf;
    logic             ovf_nx;
    logic [ACC_W:0]   add_full;
    logic             cnt_full;

    // Extra top bit of the sum captures the carry out of the accumulator.
    always_comb begin
        add_full = {1'b0, acc} + (ACC_W + 1)'(in_data);
        cnt_full = &cnt;
    end

    // Next-state, handshake outputs and accumulator update.
    always_comb begin
        state_nx  = state;
        acc_nx    = acc;
        cnt_nx    = cnt;
        ovf_nx    = ovf;
        in_ready  = (state == ACCUM);
        out_valid = (state == HOLD);
        unique case (state)
            ACCUM: begin
                if (clear) begin
                    acc_nx = '0;
                    cnt_nx = '0;
                    ovf_nx = 1'b0;
                end else if (in_valid) begin
                    acc_nx = add_full[ACC_W-1:0];
                    if (!cnt_full) begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                    ovf_nx = ovf | add_full[ACC_W] | cnt_full;
                    if (in_last) begin
                        state_nx = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nx = ACCUM;
                    acc_nx   = '0;
                    cnt_nx   = '0;
                    ovf_nx   = 1'b0;
                end
            end
            default: state_nx = ACCUM;
        endcase
    end

    // State and frame registers; reset overrides everything else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            ovf   <= ovf_nx;
        end
    end

    assign out_sum   = acc;
    assign out_count = cnt;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_add_accum_stage.sv
// tb_add_accum_stage: directed frames with a queued scoreboard; a monitor
// pops expected results on each output handshake.
module tb_add_accum_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        clear;
    logic        out_ready;
    logic [46:0] in_data;
    logic        in_last;
    logic        a_iv;
    logic        a_ir;
    logic        a_ov;
    logic [63:0] a_sum;
    logic [15:0] a_cnt;
    logic        a_ovf;
    logic        b_iv;
    logic        b_ir;
    logic        b_ov;
    logic [47:0] b_sum;
    logic [1:0]  b_cnt;
    logic        b_ovf;

    add_accum_stage dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(a_iv), .in_ready(a_ir),
        .in_data(in_data), .in_last(in_last),
        .out_valid(a_ov), .out_ready(out_ready),
        .out_sum(a_sum), .out_count(a_cnt), .out_ovf(a_ovf)
    );

    add_accum_stage #(.IN_W(47), .ACC_W(48), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(b_iv), .in_ready(b_ir),
        .in_data(in_data), .in_last(in_last),
        .out_valid(b_ov), .out_ready(out_ready),
        .out_sum(b_sum), .out_count(b_cnt), .out_ovf(b_ovf)
    );

    typedef struct packed {
        logic [63:0] sum;
        logic [15:0] cnt;
        logic        ovf;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push(input bit sel, input logic [63:0] s,
                        input logic [15:0] c, input logic o);
        exp_t e;
        e.sum = s;
        e.cnt = c;
        e.ovf = o;
        if (sel) qb.push_back(e);
        else qa.push_back(e);
    endtask

    task automatic beat(input bit sel, input logic [46:0] d, input bit last);
        int n = 0;
        while (!(sel ? b_ir : a_ir) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL beat_wait: in_ready stuck low sel=%0d", sel);
        end
        in_data = d;
        in_last = last;
        if (sel) b_iv = 1'b1;
        else a_iv = 1'b1;
        @(posedge clk);
        #1;
        a_iv    = 1'b0;
        b_iv    = 1'b0;
        in_last = 1'b0;
    endtask

    // Monitor: every accepted result must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n && out_ready && a_ov) begin
            if (qa.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL a_unexpected: got sum %0d required none",
                         a_sum);
            end else begin
                ea = qa.pop_front();
                check("a_sum", a_sum, ea.sum);
                check("a_count", 64'(a_cnt), 64'(ea.cnt));
                check("a_ovf", 64'(a_ovf), 64'(ea.ovf));
            end
        end
        if (rst_n && out_ready && b_ov) begin
            if (qb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL b_unexpected: got sum %0d required none",
                         b_sum);
            end else begin
                eb = qb.pop_front();
                check("b_sum", 64'(b_sum), eb.sum);
                check("b_count", 64'(b_cnt), 64'(eb.cnt));
                check("b_ovf", 64'(b_ovf), 64'(eb.ovf));
            end
        end
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        in_last   = 1'b0;
        a_iv      = 1'b0;
        b_iv      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("rst_in_ready", 64'(a_ir), 64'd1);
        check("rst_out_valid", 64'(a_ov), 64'd0);
        check("rst_sum", a_sum, 64'd0);
        check("rst_count", 64'(a_cnt), 64'd0);
        check("rst_ovf", 64'(a_ovf), 64'd0);
        check("rst_b_valid", 64'(b_ov), 64'd0);

        // 5+7+11, result one cycle after the last beat.
        push(0, 64'd23, 16'd3, 1'b0);
        beat(0, 47'd5, 0);
        beat(0, 47'd7, 0);
        beat(0, 47'd11, 1);
        check("latency_out_valid", 64'(a_ov), 64'd1);
        check("latency_in_ready", 64'(a_ir), 64'd0);

        // Max DSP operands.
        push(0, 64'd140741783322622, 16'd2, 1'b0);
        beat(0, 47'd140737488355327, 0);
        beat(0, 47'd4294967295, 1);
        @(posedge clk);
        #1;

        // Backpressure: held result stable, stray beat ignored.
        out_ready = 1'b0;
        push(0, 64'd3, 16'd2, 1'b0);
        beat(0, 47'd1, 0);
        beat(0, 47'd2, 1);
        a_iv    = 1'b1;
        in_data = 47'd50;
        in_last = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("hold_in_ready", 64'(a_ir), 64'd0);
            check("hold_valid", 64'(a_ov), 64'd1);
            check("hold_sum", a_sum, 64'd3);
            check("hold_count", 64'(a_cnt), 64'd2);
        end
        a_iv      = 1'b0;
        in_last   = 1'b0;
        clear     = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("hold_clear_sum", a_sum, 64'd3);
        out_ready = 1'b1;
        push(0, 64'd6, 16'd1, 1'b0);
        beat(0, 47'd6, 1);

        // Clear discards the frame and the beat presented with it.
        beat(0, 47'd9, 0);
        beat(0, 47'd9, 0);
        clear   = 1'b1;
        a_iv    = 1'b1;
        in_data = 47'd100;
        in_last = 1'b1;
        @(posedge clk);
        #1;
        clear   = 1'b0;
        a_iv    = 1'b0;
        in_last = 1'b0;
        check("clear_valid", 64'(a_ov), 64'd0);
        check("clear_ready", 64'(a_ir), 64'd1);
        check("clear_sum", a_sum, 64'd0);
        check("clear_count", 64'(a_cnt), 64'd0);
        push(0, 64'd3, 16'd1, 1'b0);
        beat(0, 47'd3, 1);

        // Mid-frame reset.
        beat(0, 47'd1, 0);
        beat(0, 47'd2, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mrst_sum", a_sum, 64'd0);
        check("mrst_count", 64'(a_cnt), 64'd0);
        check("mrst_valid", 64'(a_ov), 64'd0);
        check("mrst_ready", 64'(a_ir), 64'd1);
        push(0, 64'd4, 16'd1, 1'b0);
        beat(0, 47'd4, 1);

        // 48-bit accumulator wrap with carry-out overflow.
        push(1, 64'd140737488355325, 16'd3, 1'b1);
        repeat (2) beat(1, 47'd140737488355327, 0);
        beat(1, 47'd140737488355327, 1);

        // 2-bit counter: reaching all-ones alone is not overflow.
        push(1, 64'd3, 16'd3, 1'b0);
        beat(1, 47'd1, 0);
        beat(1, 47'd1, 0);
        beat(1, 47'd1, 1);

        // Beats past all-ones saturate the count and flag overflow.
        push(1, 64'd5, 16'd3, 1'b1);
        repeat (4) beat(1, 47'd1, 0);
        beat(1, 47'd1, 1);

        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending required 0",
                     qa.size(), qb.size());
        end
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/add_accum_stage.md
ADD_ACCUM_STAGE -- requirements
Module: add_accum_stage

Role: downstream consumer of the 47-bit DSP wide-add stage; accumulates a stream of sums into a framed total.

Interface
- REQ-001: Parameter IN_W, default 47, width of each incoming sum beat.
- REQ-002: Parameter ACC_W, default 64, accumulator and out_sum width; SHALL be at least IN_W.
- REQ-003: Parameter CNT_W, default 16, beat-counter width.
- REQ-004: clk  input  1  single clock; all state updates on rising edge.
- REQ-005: rst_n  input  1  reset; synchronous, active-low.
- REQ-006: clear  input  1  synchronous abort of the current frame.
- REQ-007: in_valid  input  1  upstream beat valid.
- REQ-008: in_ready  output  1  block accepts a beat this cycle.
- REQ-009: in_data  input  IN_W  unsigned sum from the wide-add stage.
- REQ-010: in_last  input  1  marks the final beat of a frame.
- REQ-011: out_valid  output  1  frame result available.
- REQ-012: out_ready  input  1  downstream accepts the result.
- REQ-013: out_sum  output  ACC_W  frame total, modulo 2^ACC_W.
- REQ-014: out_count  output  CNT_W  beats in the frame, saturating.
- REQ-015: out_ovf  output  1  sticky frame overflow flag.

Function
- REQ-016: FSM states ACCUM and HOLD; in_ready SHALL be 1 exactly when state is ACCUM; out_valid SHALL be 1 exactly when state is HOLD.
- REQ-017: Beat accepted when in_valid && in_ready; acc <= acc + zero-extend(in_data) to ACC_W bits, mod 2^ACC_W; cnt <= cnt + 1.
- REQ-018: Carry out of bit ACC_W-1 on any accepted add SHALL set the frame ovf flag; when cnt is all-ones, cnt SHALL hold and the ovf flag SHALL be set.
- REQ-019: Accepted beat with in_last=1: next cycle state=HOLD; out_sum, out_count and out_ovf SHALL include that beat (latency one cycle from last-beat acceptance to out_valid).
- REQ-020: In HOLD, out_sum/out_count/out_ovf SHALL stay stable until out_ready=1; on out_valid && out_ready, next cycle state=ACCUM with acc, cnt and ovf cleared to 0.
- REQ-021: Single-beat frame (first beat has in_last=1) SHALL produce out_count=1 and out_sum=in_data.
- REQ-022: clear=1 in ACCUM SHALL zero acc, cnt and ovf next cycle and discard any beat presented that cycle, even when in_last=1; state stays ACCUM.
- REQ-023: clear=1 in HOLD SHALL be ignored; the held result is not disturbed.
- REQ-024: in_data/in_last SHALL be ignored whenever in_ready=0; no beat is lost or double-counted across ACCUM/HOLD transitions.
- REQ-025: out_sum, out_count and out_ovf SHALL be driven from registers, never combinationally from inputs.

Reset
- REQ-026: rst_n=0 at a rising edge SHALL force state=ACCUM, acc=0, cnt=0, ovf=0, giving in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0 the following cycle.
- REQ-027: Reset SHALL take priority over clear, over beat acceptance and over the out_valid/out_ready handshake; reset during HOLD discards the pending result.

Verification
- REQ-028: Beats 5, 7, 11(last), out_ready=1 -> one cycle after the last beat: out_valid=1, out_sum=23, out_count=3, out_ovf=0.
- REQ-029: Beats 140737488355327 and 4294967295(last) (max DSP a and b) -> out_sum=140741783322622, out_count=2, out_ovf=0.
- REQ-030: ACC_W=48; three beats of 140737488355327, last on third -> out_sum=140737488355325, out_count=3, out_ovf=1.
- REQ-031: out_ready=0 for 4 cycles while in HOLD with in_valid=1 -> in_ready=0 throughout, outputs unchanged; first frame after release counts only beats accepted after release.
- REQ-032: Beats 9, 9, then clear=1 with beat 100(last) -> no out_valid; the next frame 3(last) yields out_sum=3, out_count=1.
- REQ-033: rst_n=0 for one cycle mid-frame after beats 1, 2 -> outputs zero the next cycle; the next frame 4(last) yields out_sum=4, out_count=1.
